// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers for the programmable FWFT FIFO
package fifo_pkg;

  function automatic int cnt_w(input int depth_width);
    return depth_width + 1;
  endfunction

  function automatic int cap(input int depth_width);
    return (1 << depth_width) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port RAM with registered read; the read register is the FWFT head
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage is deliberately left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_fwft_prog.sv
// rtl/fifo_fwft_prog.sv - FWFT FIFO with fill count, programmable thresholds, sticky flags and flush
module fifo_fwft_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_WIDTH-1:0]               din,
  input  logic                                wr_en,
  output logic                                full,
  input  logic                                rd_en,
  output logic [DATA_WIDTH-1:0]               dout,
  output logic                                empty,
  output logic [cnt_w(DEPTH_WIDTH)-1:0]       cnt,
  input  logic [cnt_w(DEPTH_WIDTH)-1:0]       af_thresh,
  input  logic [cnt_w(DEPTH_WIDTH)-1:0]       ae_thresh,
  output logic                                almost_full,
  output logic                                almost_empty,
  input  logic                                flush,
  input  logic                                clr_flags,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int CW = cnt_w(DEPTH_WIDTH);
  localparam logic [CW-1:0] MEM_FULL = CW'(1 << DEPTH_WIDTH);

  logic [DEPTH_WIDTH-1:0] r_wptr, r_rptr;
  logic [CW-1:0]          r_mcnt, r_cnt;
  logic                   r_valid, r_ovf, r_unf;
  logic                   w_full, w_wr, w_rd, w_fetch;

  assign w_full  = (r_mcnt == MEM_FULL);
  assign w_wr    = wr_en & ~w_full & ~flush;
  assign w_rd    = rd_en & r_valid & ~flush;
  // Refill the head whenever it is vacant or being consumed this cycle.
  assign w_fetch = (r_mcnt != '0) & (~r_valid | rd_en) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_mcnt  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_mcnt  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_wr)    r_wptr <= r_wptr + 1'b1;
      if (w_fetch) r_rptr <= r_rptr + 1'b1;
      r_mcnt <= r_mcnt + CW'(w_wr) - CW'(w_fetch);
      r_cnt  <= r_cnt + CW'(w_wr) - CW'(w_rd);
      if (w_fetch)   r_valid <= 1'b1;
      else if (w_rd) r_valid <= 1'b0;
    end
  end

  // A fresh violation outranks a same-cycle clear; flushed requests never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (wr_en & w_full & ~flush) | (r_ovf & ~clr_flags);
      r_unf <= (rd_en & ~r_valid & ~flush) | (r_unf & ~clr_flags);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (din),
    .i_re    (w_fetch),
    .i_raddr (r_rptr),
    .o_rdata (dout)
  );

  assign full         = w_full;
  assign empty        = ~r_valid;
  assign cnt          = r_cnt;
  assign almost_full  = (r_cnt >= af_thresh);
  assign almost_empty = (r_cnt <= ae_thresh);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: doc/fifo_fwft_prog.md
Name: fifo_fwft_prog

Overview:
- Parametrised first-word-fall-through synchronous FIFO with its own storage. Successor to the plain FWFT wrapper.
- Adds an accurate fill count and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow flags and a synchronous flush.
- Sits between streaming producers and consumers in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of din/dout in bits (>=1).
- DEPTH_WIDTH, 4, log2 of memory entries (>=1). Total capacity CAP = 2**DEPTH_WIDTH + 1: the memory plus the output register.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- full  out  1  memory full; a write is not accepted.
- rd_en  in  1  consume the word currently on dout.
- dout  out  DATA_WIDTH  head-of-FIFO data, valid while empty=0.
- empty  out  1  no valid word on dout.
- cnt  out  DEPTH_WIDTH+1  words held (memory + output register), 0..CAP.
- af_thresh  in  DEPTH_WIDTH+1  almost-full threshold.
- ae_thresh  in  DEPTH_WIDTH+1  almost-empty threshold.
- almost_full  out  1  cnt >= af_thresh.
- almost_empty  out  1  cnt <= ae_thresh.
- flush  in  1  synchronous clear of contents.
- clr_flags  in  1  clear sticky flags.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers = 0; memory count = 0; output valid = 0.
  - empty=1, full=0, cnt=0, overflow=0, underflow=0.
  - dout=0; memory contents are not reset.
- Write: accepted at a rising edge when wr_en=1 and full=0.
  - full is registered memory state. A write while full is dropped even if a read happens in the same cycle.
  - A dropped write sets overflow at that edge.
- Fetch (internal): fetch = mem_not_empty & (empty | rd_en).
  - The memory has synchronous read. The read word loads into the output register at the edge, and output valid is set.
  - If rd_en=1 while empty=0 and the memory is empty, output valid clears and empty=1 after the edge.
- First-word latency: a write at edge N into a fully empty FIFO gives empty=0 and dout=din after edge N+1.
- Throughput: one word per cycle in each direction; simultaneous read and write both succeed when neither full nor empty.
- Read: rd_en with empty=0 pops dout at the edge. rd_en with empty=1 is ignored and sets underflow.
- cnt is registered and updated every edge: +1 per accepted write, −1 per accepted read. An accepted read and write in the same cycle leave cnt unchanged.
- full = (memory count == 2**DEPTH_WIDTH). While the output register holds a word, cnt = CAP at full.
- almost_full and almost_empty are combinational compares on the registered cnt.
  - af_thresh=0 gives almost_full=1 constantly.
  - ae_thresh >= CAP gives almost_empty=1 constantly.
  - Thresholds may change at any time; the effect is immediate.
- Pointers are DEPTH_WIDTH bits and wrap modulo 2**DEPTH_WIDTH. Memory count is DEPTH_WIDTH+1 bits.
- flush=1 at an edge:
  - Pointers, count and output valid go to 0; empty=1, cnt=0 after the edge.
  - flush takes priority over a concurrent wr_en/rd_en, which are discarded without setting any flag.
  - Sticky flags are unaffected by flush.
- clr_flags=1 at an edge clears overflow and underflow. If a new violation occurs in the same cycle, the new event wins and the flag stays 1.
- Reset asserted mid-operation aborts immediately to the reset state; in-flight data is lost.

Decomposition:
- Package fifo_pkg holds:
  - cnt_w(depth_width) function returning DEPTH_WIDTH+1;
  - cap(depth_width) function returning 2**depth_width+1.
- Sub-module fifo_mem: a simple dual-port RAM, DATA_WIDTH x 2**DEPTH_WIDTH, synchronous write, synchronous registered read with a read-enable. That read register is the FWFT output register.
- fifo_fwft_prog contains pointers, counters, flags and fetch logic.

Test Plan:
- Setup: DATA_WIDTH=8, DEPTH_WIDTH=2 (CAP=5).
- Reset, then write 0xA5 at edge N -> empty=0 and dout=0xA5 after edge N+1; cnt=1 after edge N; full=0.
- Write 0x01..0x05 back-to-back with no reads -> cnt=5, full=1 at cnt 5. A 6th write of 0x06 is dropped and overflow=1. Reads then return 0x01..0x05, and empty=1 after the 5th pop.
- Hold cnt=3, then assert wr_en and rd_en together for 10 cycles with incrementing data -> cnt stays 3, order is preserved, no flags set.
- af_thresh=4, ae_thresh=1: fill 0->5 -> almost_empty=1 for cnt 0..1; almost_full=1 for cnt 4..5.
- rd_en while empty -> underflow=1 and dout/cnt unchanged. clr_flags together with a further empty read -> underflow stays 1; clr_flags alone -> underflow=0.
- With cnt=4, assert flush together with wr_en -> cnt=0 and empty=1 next cycle; overflow unchanged.
- With cnt=4, pull rst_n low mid-cycle -> outputs reset immediately, without waiting for a clock edge.
